operand_shifter: RTL
====================

OPERAND_SHIFTER -- requirements
Module: operand_shifter

Interface
REQ-001 The block SHALL take no parameters; the datapath is fixed at 32 bits to match the ALU b operand.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 The ports SHALL be, in this order:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous abort
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request
- src_sel  in  2  0 = rotated immediate, 1 = immediate-amount shift, 2 = register-amount shift, 3 = reserved (treated as 2)
- shift_type  in  2  0 = LSL, 1 = LSR, 2 = ASR, 3 = ROR
- operand  in  32  Rm value
- amount  in  8  shift amount; src_sel 1 uses [4:0], src_sel 2 uses [7:0]
- imm8  in  8  immediate byte
- rot4  in  4  immediate rotate field
- c_in  in  1  current CPSR C flag
- out_valid  out  1  result held
- out_ready  in  1  consumer (ALU stage) takes the result
- b_out  out  32  shifted operand for the ALU b input
- shc_out  out  1  shifter carry-out for logical ops

Function
REQ-004 The block SHALL be a three-state FSM with states IDLE, SHIFT and DONE.
REQ-005 in_ready SHALL equal (state == IDLE) and flush SHALL be low.
REQ-006 On acceptance (in_valid and in_ready), the block SHALL latch the working register R, carry C = c_in, mode and step count K, then go to SHIFT if K > 0, else to DONE.
REQ-007 Latch rules SHALL be:
- src_sel 0: R = {24'b0, imm8}, mode ROR, K = 2*rot4.
- src_sel 1, LSL: K = amount[4:0].
- src_sel 1, LSR or ASR: K = amount[4:0], with amount 0 meaning 32.
- src_sel 1, ROR: amount 0 means RRX, K = 1.
- src_sel 2, LSL/LSR/ASR: K = min(amount, 33).
- src_sel 2, ROR: K = amount[4:0]. If amount != 0 and amount[4:0] == 0, then K = 0 and C = operand[31].
- In every case other than src_sel 0, R = operand.
REQ-008 Each SHIFT cycle SHALL apply exactly one single-bit step and decrement K:
- LSL: C = R[31], R = R << 1.
- LSR: C = R[0], R = R >> 1.
- ASR: C = R[0], R = {R[31], R[31:1]}.
- ROR: C = R[0], R = {R[0], R[31:1]}.
- RRX: C = R[0], R = {C_old, R[31:1]}.
REQ-009 When K reaches 0 after a step, the FSM SHALL transition SHIFT -> DONE.
REQ-010 Latency from acceptance to out_valid SHALL be K+1 cycles; a zero-count request SHALL show out_valid on the next cycle.
REQ-011 In DONE, out_valid SHALL be 1, b_out = R and shc_out = C, all held stable until out_ready is high; on that cycle the FSM SHALL return to IDLE.
REQ-012 There SHALL be no same-cycle DONE->accept; back-to-back throughput SHALL be one result per K+2 cycles minimum.
REQ-013 flush high in any state SHALL force IDLE on the next edge and drop out_valid; the in-flight result SHALL be discarded and flush SHALL win over out_ready.
REQ-014 out_valid SHALL be 0 and b_out/shc_out SHALL be don't-care in IDLE and SHIFT; the bench SHALL check them only when out_valid is 1.

Reset
REQ-015 Asserting reset SHALL immediately force state IDLE, R = 0, C = 0, K = 0, out_valid = 0, in_ready = 1, b_out = 0 and shc_out = 0.
REQ-016 Reset mid-SHIFT or in DONE SHALL abandon the operation with no output.

Structure
REQ-017 A shared package simplearm_pkg SHALL hold the shift_type enum (LSL/LSR/ASR/ROR), the src_sel enum, the FSM state enum and the constant SHIFT_CLAMP = 33.
REQ-018 One combinational sub-module shift_step SHALL implement the REQ-008 single-bit step, with inputs R, C and mode, and outputs next R and next C.
REQ-019 The FSM, counter and handshake SHALL live in operand_shifter.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- src_sel 0, imm8 = 0xFF, rot4 = 4 -> after 9 cycles b_out = 0xFF000000, shc_out = 1; with rot4 = 0 and c_in = 1 -> b_out = 0x000000FF, shc_out = 1, latency 1.
- src_sel 2 LSR, operand = 0x80000001, amount = 32 -> b_out = 0, shc_out = 1; amount = 40 -> b_out = 0, shc_out = 0, latency 34.
- src_sel 1 ASR amount 0 with operand = 0x80000000 -> b_out = 0xFFFFFFFF, shc_out = 1; src_sel 1 ROR amount 0 with c_in = 1 and operand = 0x00000003 -> b_out = 0x80000001, shc_out = 1.
- src_sel 2 ROR, amount = 64, operand = 0x80000000 -> b_out = 0x80000000, shc_out = 1, latency 1.
- Backpressure: out_ready held low for 5 cycles in DONE -> out_valid, b_out and shc_out stable throughout, in_ready = 0; then one-cycle out_ready -> IDLE.
- flush at the 3rd SHIFT cycle of LSL #20, and async reset pulsed mid-SHIFT -> next cycle IDLE, out_valid = 0, in_ready = 1, with no result ever presented.

Source files
------------

// File: rtl/simplearm_pkg.sv
// rtl/simplearm_pkg.sv - shared shifter types, FSM states and constants
package simplearm_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  // register-amount shifts never need more than 33 single-bit steps
  localparam int SHIFT_CLAMP = 33;

  typedef enum logic [1:0] {
    ST_LSL = 2'd0,
    ST_LSR = 2'd1,
    ST_ASR = 2'd2,
    ST_ROR = 2'd3
  } shift_type_e;

  typedef enum logic [1:0] {
    SRC_ROT_IMM   = 2'd0,
    SRC_IMM_SHIFT = 2'd1,
    SRC_REG_SHIFT = 2'd2,
    SRC_RESERVED  = 2'd3
  } src_sel_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // per-step behaviour; RRX only arises from an immediate ROR #0
  typedef enum logic [2:0] {
    M_LSL = 3'd0,
    M_LSR = 3'd1,
    M_ASR = 3'd2,
    M_ROR = 3'd3,
    M_RRX = 3'd4
  } step_mode_e;

  function automatic step_mode_e base_mode(input shift_type_e st);
    case (st)
      ST_LSL:  return M_LSL;
      ST_LSR:  return M_LSR;
      ST_ASR:  return M_ASR;
      default: return M_ROR;
    endcase
  endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one single-bit shift/rotate step with carry
module shift_step
  import simplearm_pkg::*;
(
  input  logic [31:0] r,
  input  logic        c,
  input  step_mode_e  mode,
  output logic [31:0] r_next,
  output logic        c_next
);

  // apply exactly one bit of movement according to the latched mode
  always_comb begin
    r_next = r;
    c_next = c;
    case (mode)
      M_LSL: begin
        c_next = r[31];
        r_next = {r[30:0], 1'b0};
      end
      M_LSR: begin
        c_next = r[0];
        r_next = {1'b0, r[31:1]};
      end
      M_ASR: begin
        c_next = r[0];
        r_next = {r[31], r[31:1]};
      end
      M_ROR: begin
        c_next = r[0];
        r_next = {r[0], r[31:1]};
      end
      M_RRX: begin
        c_next = r[0];
        r_next = {c, r[31:1]};
      end
      default: begin
        r_next = r;
        c_next = c;
      end
    endcase
  end

endmodule

// File: rtl/operand_shifter.sv
// rtl/operand_shifter.sv - iterative ALU b-operand shifter with valid/ready handshake
module operand_shifter
  import simplearm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  src_sel,
  input  logic [1:0]  shift_type,
  input  logic [31:0] operand,
  input  logic [7:0]  amount,
  input  logic [7:0]  imm8,
  input  logic [3:0]  rot4,
  input  logic        c_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] b_out,
  output logic        shc_out
);

  localparam logic [7:0]       CLAMP_AMT = 8'(SHIFT_CLAMP);
  localparam logic [CNT_W-1:0] CLAMP_K   = CNT_W'(SHIFT_CLAMP);

  state_e           state_q;
  logic [31:0]      r_q;
  logic             c_q;
  logic [CNT_W-1:0] k_q;
  step_mode_e       mode_q;
  logic             out_valid_q;

  logic [31:0]      lat_r;
  logic             lat_c;
  step_mode_e       lat_mode;
  logic [CNT_W-1:0] lat_k;
  logic [4:0]       amt5;
  shift_type_e      st;

  logic [31:0]      step_r;
  logic             step_c;

  assign amt5 = amount[4:0];
  assign st   = shift_type_e'(shift_type);

  // decode the request into working value, carry, step mode and step count
  always_comb begin
    lat_r    = operand;
    lat_c    = c_in;
    lat_mode = base_mode(st);
    lat_k    = '0;
    case (src_sel_e'(src_sel))
      SRC_ROT_IMM: begin
        lat_r    = {24'b0, imm8};
        lat_mode = M_ROR;
        lat_k    = {1'b0, rot4, 1'b0};
      end
      SRC_IMM_SHIFT: begin
        case (st)
          ST_LSL: lat_k = {1'b0, amt5};
          ST_LSR, ST_ASR: lat_k = (amt5 == 5'd0) ? CNT_W'(32) : {1'b0, amt5};
          default: begin
            if (amt5 == 5'd0) begin
              lat_mode = M_RRX;
              lat_k    = CNT_W'(1);
            end else begin
              lat_k = {1'b0, amt5};
            end
          end
        endcase
      end
      default: begin
        if (st == ST_ROR) begin
          lat_k = {1'b0, amt5};
          // a whole multiple of 32 leaves the value unchanged but exposes bit 31 as carry
          if (amount != 8'd0 && amt5 == 5'd0) begin
            lat_c = operand[31];
          end
        end else begin
          lat_k = (amount > CLAMP_AMT) ? CLAMP_K : amount[CNT_W-1:0];
        end
      end
    endcase
  end

  shift_step u_step (
    .r      (r_q),
    .c      (c_q),
    .mode   (mode_q),
    .r_next (step_r),
    .c_next (step_c)
  );

  // control FSM: accept, step once per cycle until the count is spent, hold result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      r_q         <= '0;
      c_q         <= 1'b0;
      k_q         <= '0;
      mode_q      <= M_LSL;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            r_q    <= lat_r;
            c_q    <= lat_c;
            mode_q <= lat_mode;
            k_q    <= lat_k;
            if (lat_k == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r_q <= step_r;
          c_q <= step_c;
          k_q <= k_q - CNT_W'(1);
          if (k_q == CNT_W'(1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !flush;
  assign out_valid = out_valid_q;
  assign b_out     = r_q;
  assign shc_out   = c_q;

endmodule
